// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state and requester tag types for dmem_arbiter
package dmem_arbiter_pkg;

  // Read-tracking FSM states
  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // Requester identity, used both for the pending-read tag and the round-robin pointer
  typedef enum logic {
    TAG_A = 1'b0,
    TAG_B = 1'b1
  } tag_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - two-way round-robin picker
import dmem_arbiter_pkg::*;

module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  tag_t last,
  output logic gnt_a,
  output logic gnt_b
);

  // A lone requester always wins; on a tie the one not granted last wins
  assign gnt_a = req_a && (!req_b || (last == TAG_B));
  assign gnt_b = req_b && (!req_a || (last == TAG_A));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter for a single-port data memory
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_rvalid,
  output logic             b_rvalid,
  output logic             a_err,
  output logic             b_err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_write,
  output logic             mem_read,
  output logic [WIDTH-1:0] read_address,
  output logic [WIDTH-1:0] write_address,
  output logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] mem_data
);

  // One extra bit so DEPTH == 2**WIDTH still compares correctly
  localparam logic [WIDTH:0] DEPTH_LIM = (WIDTH+1)'(DEPTH);

  state_t           state;
  state_t           state_nx;
  tag_t             tag;
  tag_t             tag_nx;
  tag_t             last_gnt;
  logic             pick_a;
  logic             pick_b;
  logic             any_gnt;
  logic             sel_we;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             in_range;
  logic             err_a_q;
  logic             err_b_q;

  rr_pick2 u_pick (
    .req_a (a_req),
    .req_b (b_req),
    .last  (last_gnt),
    .gnt_a (pick_a),
    .gnt_b (pick_b)
  );

  // Grant, request mux and memory strobes; reset suppresses every grant
  always_comb begin
    a_gnt         = pick_a && !reset;
    b_gnt         = pick_b && !reset;
    any_gnt       = a_gnt || b_gnt;
    sel_we        = a_gnt ? a_we    : b_we;
    sel_addr      = a_gnt ? a_addr  : b_addr;
    sel_wdata     = a_gnt ? a_wdata : b_wdata;
    in_range      = ({1'b0, sel_addr} < DEPTH_LIM);
    mem_read      = any_gnt && !sel_we && in_range;
    mem_write     = any_gnt &&  sel_we && in_range;
    read_address  = sel_addr;
    write_address = sel_addr;
    write_data    = sel_wdata;
  end

  // Next-state: stay in RD_WAIT only while another in-range read is issued
  always_comb begin
    state_nx = IDLE;
    tag_nx   = tag;
    if (mem_read) begin
      state_nx = RD_WAIT;
      tag_nx   = a_gnt ? TAG_A : TAG_B;
    end
  end

  // FSM state and pending-read tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tag   <= TAG_A;
    end else begin
      state <= state_nx;
      tag   <= tag_nx;
    end
  end

  // Round-robin pointer and out-of-range error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= TAG_B;
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
    end else begin
      if (a_gnt) begin
        last_gnt <= TAG_A;
      end else if (b_gnt) begin
        last_gnt <= TAG_B;
      end
      err_a_q <= a_gnt && !in_range;
      err_b_q <= b_gnt && !in_range;
    end
  end

  // Read response: memory data is routed to the tagged requester, zero otherwise
  always_comb begin
    a_rvalid = (state == RD_WAIT) && (tag == TAG_A) && !reset;
    b_rvalid = (state == RD_WAIT) && (tag == TAG_B) && !reset;
    rdata    = (a_rvalid || b_rvalid) ? mem_data : '0;
    a_err    = err_a_q && !reset;
    b_err    = err_b_q && !reset;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
  logic [31:0] rdata;
  logic        mem_write, mem_read;
  logic [31:0] read_address, write_address, write_data;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] mem [0:1023] = '{default: 32'h0};

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.WIDTH(32), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_err(a_err), .b_err(b_err), .rdata(rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .read_address(read_address), .write_address(write_address),
    .write_data(write_data), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Attached memory: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_write) mem[write_address[9:0]] <= write_data;
    if (mem_read)  mem_data <= mem[read_address[9:0]];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // flags = {a_gnt, b_gnt, mem_read, mem_write, a_rvalid, b_rvalid, a_err, b_err}
  typedef struct {
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic [7:0]  flags;
    logic [31:0] addr, wdata, rd;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                              input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
                              input logic [7:0] f, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [31:0] er);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.flags = f; v.addr = ea; v.wdata = ed; v.rd = er;
    return v;
  endfunction

  task automatic drive(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  vec_t vecs[15];

  // Random-phase model state
  logic        pa, pb, pa_we, pb_we;
  logic [31:0] pa_addr, pb_addr, pa_wd, pb_wd;
  logic        last_b;
  logic [31:0] shadow [0:15];
  logic        x_arv, x_brv, x_aerr, x_berr;
  logic [31:0] x_rd;
  int          wait_a, wait_b;

  initial begin
    vecs[0]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0, 8'b1001_0000, 5, 32'hDEADBEEF, 0);
    vecs[1]  = mk(1,0,5,0,            0,0,0,0, 8'b1010_0000, 5, 0, 0);
    vecs[2]  = mk(0,0,0,0,            0,0,0,0, 8'b0000_1000, 0, 0, 32'hDEADBEEF);
    vecs[3]  = mk(1,1,1,32'h11111111, 0,0,0,0, 8'b1001_0000, 1, 32'h11111111, 0);
    vecs[4]  = mk(0,0,0,0, 1,1,2,32'h22222222, 8'b0101_0000, 2, 32'h22222222, 0);
    vecs[5]  = mk(1,0,1,0, 1,0,2,0,            8'b1010_0000, 1, 0, 0);
    vecs[6]  = mk(1,0,1,0, 1,0,2,0,            8'b0110_1000, 2, 0, 32'h11111111);
    vecs[7]  = mk(1,0,1,0, 1,0,2,0,            8'b1010_0100, 1, 0, 32'h22222222);
    vecs[8]  = mk(1,0,1,0, 1,0,2,0,            8'b0110_1000, 2, 0, 32'h11111111);
    vecs[9]  = mk(0,0,0,0, 0,0,0,0,            8'b0000_0100, 0, 0, 32'h22222222);
    vecs[10] = mk(0,0,0,0, 1,0,1024,0,         8'b0100_0000, 0, 0, 0);
    vecs[11] = mk(0,0,0,0, 0,0,0,0,            8'b0000_0001, 0, 0, 0);
    vecs[12] = mk(1,1,2000,32'h5A5A5A5A, 0,0,0,0, 8'b1000_0000, 0, 0, 0);
    vecs[13] = mk(0,0,0,0, 0,0,0,0,            8'b0000_0010, 0, 0, 0);
    vecs[14] = mk(0,0,0,0, 0,0,0,0,            8'b0000_0000, 0, 0, 0);

    // Reset holds every grant and strobe low even with both requesting
    reset = 1'b1;
    drive(1,0,5,0, 1,0,6,0);
    #1;
    check("reset_outputs",
          {56'h0, a_gnt, b_gnt, mem_read, mem_write, a_rvalid, b_rvalid, a_err, b_err}, 64'h0);
    check("reset_rdata", {32'h0, rdata}, 64'h0);
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
            vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
      #1;
      check($sformatf("vec%0d_flags", i),
            {56'h0, a_gnt, b_gnt, mem_read, mem_write, a_rvalid, b_rvalid, a_err, b_err},
            {56'h0, vecs[i].flags});
      check($sformatf("vec%0d_rdata", i), {32'h0, rdata}, {32'h0, vecs[i].rd});
      if (vecs[i].flags[5])
        check($sformatf("vec%0d_raddr", i), {32'h0, read_address}, {32'h0, vecs[i].addr});
      if (vecs[i].flags[4])
        check($sformatf("vec%0d_waddr", i), {write_address, write_data},
              {vecs[i].addr, vecs[i].wdata});
    end

    // Reset landing on the RD_WAIT cycle drops the pending read
    @(negedge clk);
    drive(1,0,5,0, 0,0,0,0);
    #1;
    check("rst_rd_gnt", {62'h0, a_gnt, mem_read}, 64'h3);
    @(posedge clk);
    reset = 1'b1;
    drive(0,0,0,0, 0,0,0,0);
    #1;
    check("rst_rd_rvalid_early", {62'h0, a_rvalid, b_rvalid}, 64'h0);
    @(negedge clk);
    check("rst_rd_rvalid_mid", {62'h0, a_rvalid, b_rvalid}, 64'h0);
    reset = 1'b0;
    #1;
    check("rst_rd_rvalid_rel", {62'h0, a_rvalid, b_rvalid}, 64'h0);
    @(negedge clk);
    drive(1,0,1,0, 1,0,2,0);
    #1;
    check("rst_tie_to_a", {62'h0, a_gnt, b_gnt}, 64'h2);
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);

    // Fresh reset, then random traffic against a scoreboard
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pa = 0; pb = 0; last_b = 1; wait_a = 0; wait_b = 0;
    x_arv = 0; x_brv = 0; x_aerr = 0; x_berr = 0; x_rd = 0;
    pa_we = 0; pb_we = 0; pa_addr = 0; pb_addr = 0; pa_wd = 0; pb_wd = 0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        ea, eb, g_we, inr, e_rd, e_wr;
      logic [31:0] g_addr, g_wd;
      @(negedge clk);
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1; pa_we = 1'($urandom_range(0, 1)); pa_wd = $urandom;
        pa_addr = ($urandom_range(0, 9) == 0) ? 32'd1024 + $urandom_range(0, 7) : 32'd16 + $urandom_range(0, 15);
      end
      if (!pb && $urandom_range(0, 9) < 6) begin
        pb = 1; pb_we = 1'($urandom_range(0, 1)); pb_wd = $urandom;
        pb_addr = ($urandom_range(0, 9) == 0) ? 32'd1024 + $urandom_range(0, 7) : 32'd16 + $urandom_range(0, 15);
      end
      drive(pa, pa_we, pa_addr, pa_wd, pb, pb_we, pb_addr, pb_wd);
      #1;
      ea = pa && (!pb || last_b);
      eb = pb && (!pa || !last_b);
      g_we   = ea ? pa_we   : pb_we;
      g_addr = ea ? pa_addr : pb_addr;
      g_wd   = ea ? pa_wd   : pb_wd;
      inr    = g_addr < 32'd1024;
      e_rd   = (ea || eb) && !g_we && inr;
      e_wr   = (ea || eb) &&  g_we && inr;
      check("rnd_gnt", {62'h0, a_gnt, b_gnt}, {62'h0, ea, eb});
      check("rnd_excl", {63'h0, mem_read && mem_write}, 64'h0);
      check("rnd_strobe", {62'h0, mem_read, mem_write}, {62'h0, e_rd, e_wr});
      if (e_rd) check("rnd_raddr", {32'h0, read_address}, {32'h0, g_addr});
      if (e_wr) check("rnd_wdata", {write_address, write_data}, {g_addr, g_wd});
      check("rnd_resp", {28'h0, a_rvalid, b_rvalid, a_err, b_err, rdata},
            {28'h0, x_arv, x_brv, x_aerr, x_berr, (x_arv || x_brv) ? x_rd : 32'h0});
      x_arv  = ea && e_rd;
      x_brv  = eb && e_rd;
      x_rd   = e_rd ? shadow[g_addr[3:0]] : 32'h0;
      x_aerr = ea && !inr;
      x_berr = eb && !inr;
      if (e_wr) shadow[g_addr[3:0]] = g_wd;
      if (ea) begin pa = 0; wait_a = 0; last_b = 0; end
      else if (pa) begin
        wait_a++;
        check("rnd_wait_a", {63'h0, wait_a > 1}, 64'h0);
      end
      if (eb) begin pb = 0; wait_b = 0; last_b = 1; end
      else if (pb) begin
        wait_b++;
        check("rnd_wait_b", {63'h0, wait_b > 1}, 64'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
